// File: rtl/pkg.sv
// Shared types and constants for the direct-mapped cache controller.
// The backing-memory image function supplies the power-up contents mem[a] = a[7:0].
package pkg;

  localparam int ADDR_W    = 12;
  localparam int DATA_W    = 8;
  localparam int MEM_DEPTH = 1 << ADDR_W;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOOKUP  = 2'd1,
    FILL    = 2'd2,
    RESPOND = 2'd3
  } cache_state_e;

  typedef logic [DATA_W-1:0] mem_t [0:MEM_DEPTH-1];

  function automatic mem_t mem_image();
    mem_t m;
    for (int a = 0; a < MEM_DEPTH; a++) begin
      m[a] = a[DATA_W-1:0];
    end
    return m;
  endfunction

endpackage

// File: rtl/cache_ctrl_if.sv
// Processor-side request/response bundle of the cache controller.
// The bidirectional data bus stays a plain port on the controller.
interface cache_ctrl_if;
  import pkg::*;

  logic              valid;
  logic              rw;
  logic [ADDR_W-1:0] address_cache;
  logic              gnt;
  logic              hit;
  logic              busy;
  logic [15:0]       hit_cnt;
  logic [15:0]       miss_cnt;

  modport master (
    output valid, rw, address_cache,
    input  gnt, hit, busy, hit_cnt, miss_cnt
  );

  modport slave (
    input  valid, rw, address_cache,
    output gnt, hit, busy, hit_cnt, miss_cnt
  );

endinterface

// File: rtl/cache_array.sv
// Tag, data and valid storage for the direct-mapped lines.
// One synchronous write port, one asynchronous read port, synchronous clear of all valid bits.
module cache_array
  import pkg::*;
#(
  parameter int LINES = 16,
  parameter int IDX_W = $clog2(LINES),
  parameter int TAG_W = ADDR_W - IDX_W
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              we,
  input  logic [IDX_W-1:0]  widx,
  input  logic [TAG_W-1:0]  wtag,
  input  logic [DATA_W-1:0] wdata,
  input  logic [IDX_W-1:0]  ridx,
  output logic              rvalid,
  output logic [TAG_W-1:0]  rtag,
  output logic [DATA_W-1:0] rdata
);

  logic [TAG_W-1:0]  tag_q  [LINES];
  logic [DATA_W-1:0] data_q [LINES];
  logic [LINES-1:0]  valid_q;

  always_ff @(posedge clk) begin
    if (we) begin
      tag_q[widx]  <= wtag;
      data_q[widx] <= wdata;
    end
  end

  // Valid bits are the only line state that clear touches.
  for (genvar gi = 0; gi < LINES; gi++) begin : g_valid
    always_ff @(posedge clk) begin
      if (clr) begin
        valid_q[gi] <= 1'b0;
      end else if (we && (widx == IDX_W'(gi))) begin
        valid_q[gi] <= 1'b1;
      end
    end
  end

  assign rvalid = valid_q[ridx];
  assign rtag   = tag_q[ridx];
  assign rdata  = data_q[ridx];

endmodule

// File: rtl/cache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate byte cache in front of a 4096x8 memory.
// Outputs are decoded from the registered FSM state, so reset clears them on the next edge.
module cache_ctrl
  import pkg::*;
#(
  parameter int LINES    = 16,
  parameter int MISS_LAT = 4
) (
  input  logic              clk,
  input  logic              rst,
  cache_ctrl_if.slave       bus,
  inout  wire  [DATA_W-1:0] data_cache
);

  localparam int IDX_W = $clog2(LINES);
  localparam int TAG_W = ADDR_W - IDX_W;
  localparam int CNT_W = $clog2(MISS_LAT) + 1;

  cache_state_e      state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              hit_q, hit_d;
  logic [ADDR_W-1:0] addr_q;
  logic              rw_q;
  logic [DATA_W-1:0] wdata_q;
  logic [15:0]       hit_cnt_q, miss_cnt_q;
  logic [DATA_W-1:0] mem_rdata_q;
  mem_t              mem_q = mem_image();

  logic              line_we;
  logic [DATA_W-1:0] line_wdata;
  logic              mem_we;
  logic              line_valid;
  logic [TAG_W-1:0]  line_tag;
  logic [DATA_W-1:0] line_data;
  logic              lookup_hit;

  cache_array #(
    .LINES (LINES),
    .IDX_W (IDX_W),
    .TAG_W (TAG_W)
  ) u_array (
    .clk    (clk),
    .clr    (rst),
    .we     (line_we && !rst),
    .widx   (addr_q[IDX_W-1:0]),
    .wtag   (addr_q[ADDR_W-1:IDX_W]),
    .wdata  (line_wdata),
    .ridx   (addr_q[IDX_W-1:0]),
    .rvalid (line_valid),
    .rtag   (line_tag),
    .rdata  (line_data)
  );

  assign lookup_hit = line_valid && (line_tag == addr_q[ADDR_W-1:IDX_W]);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    hit_d      = hit_q;
    line_we    = 1'b0;
    line_wdata = wdata_q;
    mem_we     = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.valid) state_d = LOOKUP;
      end
      LOOKUP: begin
        hit_d = lookup_hit;
        cnt_d = '0;
        state_d = (rw_q && !lookup_hit) ? FILL : RESPOND;
      end
      FILL: begin
        if (cnt_q == CNT_W'(MISS_LAT - 1)) begin
          line_we    = 1'b1;
          line_wdata = mem_rdata_q;
          cnt_d      = '0;
          state_d    = RESPOND;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RESPOND: begin
        state_d = IDLE;
        if (!rw_q) begin
          mem_we  = 1'b1;
          line_we = hit_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      hit_q      <= 1'b0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hit_q   <= hit_d;
      if (state_q == RESPOND) begin
        if (hit_q && (hit_cnt_q != 16'hFFFF)) hit_cnt_q <= hit_cnt_q + 16'd1;
        if (!hit_q && (miss_cnt_q != 16'hFFFF)) miss_cnt_q <= miss_cnt_q + 16'd1;
      end
    end
  end

  // Request capture is pure datapath; an abort simply leaves stale values behind.
  always_ff @(posedge clk) begin
    if ((state_q == IDLE) && bus.valid && !rst) begin
      addr_q <= bus.address_cache;
      rw_q   <= bus.rw;
      if (!bus.rw) wdata_q <= data_cache;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we && !rst) mem_q[addr_q] <= wdata_q;
    mem_rdata_q <= mem_q[addr_q];
  end

  assign bus.gnt      = (state_q == RESPOND);
  assign bus.hit      = (state_q == RESPOND) && hit_q;
  assign bus.busy     = (state_q != IDLE);
  assign bus.hit_cnt  = hit_cnt_q;
  assign bus.miss_cnt = miss_cnt_q;

  assign data_cache = ((state_q == RESPOND) && rw_q) ? line_data : {DATA_W{1'bz}};

endmodule

// File: tb/tb_cache_ctrl.sv
// Directed bench for cache_ctrl: hit/miss latency, write-through, aliasing and mid-fill reset.
// Expected values are hand-computed for LINES=16, MISS_LAT=4 (index = addr[3:0]).
module tb_cache_ctrl;

  logic       clk;
  logic       rst;
  logic [7:0] tb_dq;
  logic       tb_den;
  wire  [7:0] data_cache;
  int         n_checks;
  int         n_fail;

  cache_ctrl_if bus ();

  assign data_cache = tb_den ? tb_dq : 8'bz;

  cache_ctrl #(
    .LINES    (16),
    .MISS_LAT (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus.slave),
    .data_cache (data_cache)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Drive a probe value; if the DUT is also driving, the bus will not read back cleanly.
  task automatic probe_z(input string tag);
    tb_dq  = 8'h5A;
    tb_den = 1'b1;
    #1;
    check(tag, {24'd0, data_cache}, 32'h5A);
    tb_den = 1'b0;
  endtask

  task automatic do_req(input string tag, input logic r, input logic [11:0] a,
                        input logic [7:0] wd, input int exp_lat, input logic exp_hit,
                        input logic [7:0] exp_d, input logic [15:0] exp_hc,
                        input logic [15:0] exp_mc);
    int   lat;
    logic seen;
    logic hit_s;
    logic [7:0] d_s;
    @(negedge clk);
    bus.valid         = 1'b1;
    bus.rw            = r;
    bus.address_cache = a;
    if (!r) begin
      tb_dq  = wd;
      tb_den = 1'b1;
    end
    @(posedge clk);
    #1;
    bus.valid = 1'b0;
    tb_den    = 1'b0;
    lat   = 0;
    seen  = 1'b0;
    hit_s = 1'b0;
    d_s   = 8'h00;
    for (int k = 1; k <= 20 && !seen; k++) begin
      @(negedge clk);
      if (bus.gnt) begin
        seen  = 1'b1;
        lat   = k;
        hit_s = bus.hit;
        d_s   = data_cache;
      end
    end
    check({tag, "_gnt_seen"}, 32'(seen), 32'd1);
    check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    check({tag, "_hit"}, 32'(hit_s), 32'(exp_hit));
    if (r) check({tag, "_data"}, {24'd0, d_s}, {24'd0, exp_d});
    else   probe_z({tag, "_wr_z"});
    @(posedge clk);
    #1;
    check({tag, "_gnt_low"}, 32'(bus.gnt), 32'd0);
    check({tag, "_busy_low"}, 32'(bus.busy), 32'd0);
    check({tag, "_hit_cnt"}, 32'(bus.hit_cnt), 32'(exp_hc));
    check({tag, "_miss_cnt"}, 32'(bus.miss_cnt), 32'(exp_mc));
    $display("txn %s rw=%0d addr=0x%03h lat=%0d hit=%0d data=0x%02h hc=%0d mc=%0d",
             tag, r, a, lat, hit_s, d_s, bus.hit_cnt, bus.miss_cnt);
  endtask

  initial begin
    int gnt_seen;
    n_checks          = 0;
    n_fail            = 0;
    tb_dq             = 8'h00;
    tb_den            = 1'b0;
    bus.valid         = 1'b0;
    bus.rw            = 1'b1;
    bus.address_cache = 12'h000;
    rst               = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_gnt", 32'(bus.gnt), 32'd0);
    check("rst_hit", 32'(bus.hit), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_hit_cnt", 32'(bus.hit_cnt), 32'd0);
    check("rst_miss_cnt", 32'(bus.miss_cnt), 32'd0);
    probe_z("rst_data_z");
    $display("txn reset gnt=%0d busy=%0d", bus.gnt, bus.busy);

    //      tag          rw    addr     wd     lat hit data   hc  mc
    do_req("rd123_miss", 1'b1, 12'h123, 8'h00, 6, 1'b0, 8'h23, 0, 1);
    do_req("rd123_hit",  1'b1, 12'h123, 8'h00, 2, 1'b1, 8'h23, 1, 1);
    do_req("wr123_hit",  1'b0, 12'h123, 8'hA5, 2, 1'b1, 8'h00, 2, 1);
    do_req("rd123_new",  1'b1, 12'h123, 8'h00, 2, 1'b1, 8'hA5, 3, 1);
    do_req("rd223_alias",1'b1, 12'h223, 8'h00, 6, 1'b0, 8'h23, 3, 2);
    do_req("rd123_wt",   1'b1, 12'h123, 8'h00, 6, 1'b0, 8'hA5, 3, 3);
    do_req("wr456_miss", 1'b0, 12'h456, 8'h3C, 2, 1'b0, 8'h00, 3, 4);
    do_req("rd456_noalc",1'b1, 12'h456, 8'h00, 6, 1'b0, 8'h3C, 3, 5);

    // Reset during the second FILL cycle of a read miss.
    @(negedge clk);
    bus.valid         = 1'b1;
    bus.rw            = 1'b1;
    bus.address_cache = 12'h789;
    @(posedge clk);
    #1;
    bus.valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("abort_busy_fill", 32'(bus.busy), 32'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("abort_busy", 32'(bus.busy), 32'd0);
    check("abort_gnt", 32'(bus.gnt), 32'd0);
    probe_z("abort_data_z");
    @(negedge clk);
    rst = 1'b0;
    gnt_seen = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (bus.gnt) gnt_seen++;
    end
    check("abort_no_gnt", 32'(gnt_seen), 32'd0);
    check("abort_hit_cnt", 32'(bus.hit_cnt), 32'd0);
    check("abort_miss_cnt", 32'(bus.miss_cnt), 32'd0);
    $display("txn abort busy=%0d gnt_after=%0d", bus.busy, gnt_seen);

    // Reset wins over a simultaneous request.
    @(negedge clk);
    rst               = 1'b1;
    bus.valid         = 1'b1;
    bus.rw            = 1'b1;
    bus.address_cache = 12'h456;
    @(posedge clk);
    #1;
    check("rst_prio_busy", 32'(bus.busy), 32'd0);
    @(negedge clk);
    rst       = 1'b0;
    bus.valid = 1'b0;
    $display("txn rst_prio busy=%0d", bus.busy);

    do_req("rd456_after",1'b1, 12'h456, 8'h00, 6, 1'b0, 8'h3C, 0, 1);
    do_req("rd123_after",1'b1, 12'h123, 8'h00, 6, 1'b0, 8'hA5, 0, 2);
    do_req("rd123_rehit",1'b1, 12'h123, 8'h00, 2, 1'b1, 8'hA5, 1, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
